// File: rtl/mem_stage_if.sv
// Data-memory port bundle between the MEM stage and data memory.
// The stage is the master; memory answers with ack and read data.
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_be;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_be,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_be,
        output dmem_ack,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// MEM stage: variable-latency data-memory handshake, byte lane
// alignment, pipeline stall generation and the MEM/WB register.
module mem_stage #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memWrite_E_MEM,
    input  logic        mem_read_MEM,
    input  logic        MemToReg_MEM,
    input  logic        regWrite_E_MEM,
    input  logic [4:0]  regWrite_MEM,
    input  logic [63:0] ALU_out_MEM,
    input  logic [63:0] mem_Din_MEM,
    input  logic        byte_MEM,
    mem_stage_if.master bus,
    output logic        stall_MEM,
    output logic        dmem_err,
    output logic        regWrite_E_WB,
    output logic        MemToReg_WB,
    output logic [4:0]  regWrite_WB,
    output logic [63:0] ALU_out_WB,
    output logic [63:0] mem_Dout_WB
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam logic [7:0] LP_MAX = 8'(MAX_WAIT);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_err;
    logic        r_rwe;
    logic        r_m2r;
    logic [4:0]  r_rd;
    logic [63:0] r_alu;
    logic [63:0] r_dout;

    logic [2:0]  w_off;
    logic        w_active;
    logic        w_misalign;
    logic        w_legal;
    logic        w_req;
    logic        w_limit;
    logic        w_abort;
    logic        w_stall;
    logic [7:0]  w_byte;
    logic [63:0] w_load;

    assign w_off      = ALU_out_MEM[2:0];
    assign w_active   = memWrite_E_MEM | mem_read_MEM;
    assign w_misalign = w_active & ~byte_MEM & (w_off != 3'd0);
    assign w_legal    = w_active & ~w_misalign;
    assign w_req      = reset & w_legal;
    assign w_limit    = (r_state == S_WAIT) && (r_cnt == LP_MAX);
    assign w_abort    = w_req & ~bus.dmem_ack & w_limit;
    assign w_stall    = w_req & ~bus.dmem_ack & ~w_limit;
    assign w_byte     = bus.dmem_rdata[{w_off, 3'b000} +: 8];

    // Load data: a store wins over a simultaneous load and returns 0.
    always_comb begin
        w_load = '0;
        if (mem_read_MEM && !memWrite_E_MEM) begin
            if (byte_MEM) begin
                w_load = {56'd0, w_byte};
            end else begin
                w_load = bus.dmem_rdata;
            end
        end
    end

    assign bus.dmem_req   = w_req;
    assign bus.dmem_we    = w_req & memWrite_E_MEM;
    assign bus.dmem_addr  = {ALU_out_MEM[63:3], 3'b000};
    assign bus.dmem_wdata = byte_MEM ? {8{mem_Din_MEM[7:0]}}
                                     : mem_Din_MEM;
    assign bus.dmem_be    = byte_MEM ? (8'b1 << w_off) : 8'hFF;

    assign stall_MEM     = w_stall;
    assign dmem_err      = r_err;
    assign regWrite_E_WB = r_rwe;
    assign MemToReg_WB   = r_m2r;
    assign regWrite_WB   = r_rd;
    assign ALU_out_WB    = r_alu;
    assign mem_Dout_WB   = r_dout;

    // Handshake FSM: count cycles spent waiting for ack.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_stall) begin
                        r_state <= S_WAIT;
                        r_cnt   <= 8'd1;
                    end
                end
                S_WAIT: begin
                    if (!w_stall) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    // Sticky error on misalignment or timeout, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_misalign || w_abort) begin
            r_err <= 1'b1;
        end
    end

    // MEM/WB register: bubble while stalled or on a failed access.
    always_ff @(posedge clk) begin
        if (!reset || w_stall || w_misalign || w_abort) begin
            r_rwe  <= 1'b0;
            r_m2r  <= 1'b0;
            r_rd   <= '0;
            r_alu  <= '0;
            r_dout <= '0;
        end else begin
            r_rwe  <= regWrite_E_MEM;
            r_m2r  <= MemToReg_MEM;
            r_rd   <= regWrite_MEM;
            r_alu  <= ALU_out_MEM;
            r_dout <= w_load;
        end
    end

endmodule
